hex_display_ctrl: RTL and testbench
===================================

Name: hex_display_ctrl

Overview:
- Parametrised multi-digit hexadecimal driver for the board's active-low 7-segment displays. It generalises the single-digit hex decoder to NUM_DIGITS digits.
- Adds three features:
  - a load/ready handshake that snapshots the value;
  - a sequential one-digit-per-cycle decode scan through a shared decoder;
  - optional leading-zero blanking and per-digit blinking.
- Sits between datapath/debug registers and the HEX display pins.

Parameters:
- NUM_DIGITS, default 6: number of digits driven. Must be at least 1.
- BLINK_DIV, default 25000000: clock cycles per blink phase. At 50 MHz this gives 0.5 s on and 0.5 s off. Must be at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- value_in  in  4*NUM_DIGITS  hex value. Digit d is value_in[4d+3:4d]; digit 0 is least significant.
- load  in  1  request to display value_in; accepted when load && ready.
- blank_lz  in  1  leading-zero blanking enable; sampled with value_in on accept.
- blink_en  in  1  global blink enable; live, not latched.
- blink_mask  in  NUM_DIGITS  per-digit blink select; live.
- ready  out  1  high when idle and able to accept a load.
- done  out  1  one-cycle pulse when a scan completes.
- hex_out  out  7*NUM_DIGITS  segments. Digit d is hex_out[7d+6:7d], bit order {g,f,e,d,c,b,a}, active low (0 = segment on).

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-scan):
  - all digit registers = 7'h7F (all segments off);
  - ready = 1, done = 0;
  - scan state = IDLE;
  - blink counter = 0, blink phase = 0;
  - latched value and latched blank_lz = 0;
  - any scan in progress is abandoned.
- Segment encoding (active low):
  - digits: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=18;
  - letters: A=08, b=03, c=27, d=21, E=06, F=0E.
- FSM states: IDLE and SCAN.
  - IDLE: ready = 1. On an edge with load = 1, latch value_in and blank_lz, clear the nonzero-seen flag, set idx = NUM_DIGITS-1, go to SCAN, ready = 0.
  - SCAN: ready = 0 and load is ignored (not queued). On each edge:
    - write digit register[idx];
    - set nz |= (nibble != 0);
    - decrement idx.
  - SCAN exit: on the edge that writes idx 0, go to IDLE, set ready = 1, and set done = 1 for exactly the following cycle.
- Latency:
  - digit NUM_DIGITS-1 is updated 1 edge after accept, digit 0 after NUM_DIGITS edges;
  - ready returns NUM_DIGITS cycles after accept;
  - a new load may be accepted in the same cycle that done is high;
  - digits not yet rewritten keep their old value during a scan.
- Leading-zero blanking: a digit is written as 7'h7F when all of the following hold:
  - latched blank_lz = 1;
  - nz = 0;
  - nibble = 0;
  - idx != 0.
  Otherwise the digit is decoded normally. Digit 0 is never blanked, so a value of 0 shows a single "0".
- Blink counter:
  - with blink_en = 1: counts 0..BLINK_DIV-1; at terminal count it wraps to 0 and toggles phase;
  - with blink_en = 0: counter and phase are held at 0 synchronously.
- Output gating (combinational from registers):
  - hex_out digit d = 7'h7F when blink_en && phase && blink_mask[d];
  - otherwise hex_out digit d = digit register d.
- Width rules:
  - counter width = $clog2(BLINK_DIV), minimum 1;
  - idx width = $clog2(NUM_DIGITS), minimum 1.
  - NUM_DIGITS = 1: the scan takes 1 cycle and no blanking ever occurs.

Decomposition:
- Package hex_display_pkg contains:
  - the segment type (7-bit);
  - the constant SEG_BLANK = 7'h7F;
  - the 16-entry hex-to-segment encoding function/constants;
  - the FSM state enum.
- Sub-module hex_seg_decode: a single combinational 4-bit to 7-bit active-low decoder, instantiated once and shared by the scan. The decoder is not replicated per digit.

Test Plan:
- Digit-by-digit update and timing. Reset, then load value 0x00012F with blank_lz=1 (NUM_DIGITS=6).
  - Digits 5..3 = 7F, digit 2 = 79, digit 1 = 24, digit 0 = 0E.
  - ready is low for exactly 6 cycles; done pulses in the cycle after the 6th edge.
- Zero values. Load 0x000000 with blank_lz=1 → digits 5..1 = 7F, digit 0 = 40. Then load 0x000000 with blank_lz=0 → all six digits = 40.
- Busy-load rejection. Load 0xABCDEF, then assert load with 0x123456 on scan cycle 2 → the second load is ignored. Final display is 08,03,27,21,06,0E; a load asserted on the done cycle is accepted.
- Blinking (BLINK_DIV=4). blink_en=1, blink_mask=6'b000001 → digit 0 alternates between its value and 7F every 4 cycles while other digits stay steady. Dropping blink_en restores the value on the next cycle, with phase = 0.
- Mid-scan reset. Assert reset asynchronously after 3 scan edges → all digits immediately show 7F, ready=1, done=0. A fresh load after release completes normally.
- Full value set. With NUM_DIGITS=1, load each of 0x0–0xF → each encoding matches the table after 1 edge, and done pulses each time.

Source files
------------

// File: rtl/hex_display_pkg.sv
// Shared types and constants for the multi-digit active-low hex display driver.
package hex_display_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'h7F;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   // Bit order {g,f,e,d,c,b,a}; a 0 lights the segment.
   function automatic seg_t hex_to_seg(input logic [3:0] nibble);
      seg_t seg;
      case (nibble)
         4'h0:    seg = 7'h40;
         4'h1:    seg = 7'h79;
         4'h2:    seg = 7'h24;
         4'h3:    seg = 7'h30;
         4'h4:    seg = 7'h19;
         4'h5:    seg = 7'h12;
         4'h6:    seg = 7'h02;
         4'h7:    seg = 7'h78;
         4'h8:    seg = 7'h00;
         4'h9:    seg = 7'h18;
         4'hA:    seg = 7'h08;
         4'hB:    seg = 7'h03;
         4'hC:    seg = 7'h27;
         4'hD:    seg = 7'h21;
         4'hE:    seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Single shared 4-bit to 7-segment active-low decoder used by the digit scan.
module hex_seg_decode
   import hex_display_pkg::*;
(
   input  logic [3:0] nibble,
   output seg_t       seg
);

   // Pure table lookup; one instance serves every digit in turn.
   always_comb begin
      seg = hex_to_seg(nibble);
   end

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit hex display driver: snapshots a value on load, decodes one digit
// per cycle from the most significant down, with leading-zero blanking and
// per-digit blinking applied on the way out.
module hex_display_ctrl
   import hex_display_pkg::*;
#(
   parameter int NUM_DIGITS = 6,
   parameter int BLINK_DIV  = 25000000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic                    load,
   input  logic                    blank_lz,
   input  logic                    blink_en,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   output logic                    ready,
   output logic                    done,
   output logic [7*NUM_DIGITS-1:0] hex_out
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   state_t                  state, next_state;
   logic [IDX_W-1:0]        idx;
   logic [4*NUM_DIGITS-1:0] val_lat;
   logic                    blz_lat;
   logic                    nz;
   seg_t                    digit_q [NUM_DIGITS];
   logic [3:0]              nibble;
   seg_t                    dec_seg;
   seg_t                    wr_seg;
   logic                    accept;
   logic                    last;
   logic [CNT_W-1:0]        blink_cnt;
   logic                    phase;

   hex_seg_decode u_dec (
      .nibble (nibble),
      .seg    (dec_seg)
   );

   assign ready = (state == IDLE);

   // State register; reset abandons any scan in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next state: accept a load only when idle, leave the scan after digit 0.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      last       = 1'b0;
      case (state)
         IDLE: begin
            if (load) begin
               accept     = 1'b1;
               next_state = SCAN;
            end
         end
         SCAN: begin
            if (idx == '0) begin
               last       = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Pick the nibble being decoded this cycle and apply leading-zero blanking;
   // digit 0 is never blanked so an all-zero value still shows a single 0.
   always_comb begin
      nibble = '0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (idx == IDX_W'(d)) nibble = val_lat[4*d +: 4];
      end
      wr_seg = (blz_lat && !nz && (nibble == 4'h0) && (idx != '0)) ? SEG_BLANK : dec_seg;
   end

   // Scan datapath: snapshot on accept, then write one digit register per edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx     <= '0;
         val_lat <= '0;
         blz_lat <= 1'b0;
         nz      <= 1'b0;
         done    <= 1'b0;
         for (int d = 0; d < NUM_DIGITS; d++) digit_q[d] <= SEG_BLANK;
      end else begin
         done <= last;
         if (accept) begin
            val_lat <= value_in;
            blz_lat <= blank_lz;
            nz      <= 1'b0;
            idx     <= IDX_W'(NUM_DIGITS - 1);
         end else if (state == SCAN) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
               if (idx == IDX_W'(d)) digit_q[d] <= wr_seg;
            end
            nz  <= nz | (nibble != 4'h0);
            idx <= idx - 1'b1;
         end
      end
   end

   // Blink timebase: free-runs while enabled, parked at zero when disabled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (!blink_en) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
         blink_cnt <= '0;
         phase     <= ~phase;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_out
      assign hex_out[7*d +: 7] = (blink_en && phase && blink_mask[d]) ? SEG_BLANK : digit_q[d];
   end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl: a six-digit instance with a fast blink
// and a single-digit instance, checked against a scoreboard of expected displays.
module tb_hex_display_ctrl;

   logic        clk;
   logic        reset;
   logic [23:0] value_in;
   logic        load;
   logic        blank_lz;
   logic        blink_en;
   logic [5:0]  blink_mask;
   logic        ready;
   logic        done;
   logic [41:0] hex_out;

   logic [3:0]  value_in1;
   logic        load1;
   logic        blank_lz1;
   logic        ready1;
   logic        done1;
   logic [6:0]  hex_out1;

   logic [41:0] exp_q [$];
   int          tests = 0;
   int          fails = 0;

   hex_display_ctrl #(.NUM_DIGITS(6), .BLINK_DIV(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .value_in   (value_in),
      .load       (load),
      .blank_lz   (blank_lz),
      .blink_en   (blink_en),
      .blink_mask (blink_mask),
      .ready      (ready),
      .done       (done),
      .hex_out    (hex_out)
   );

   hex_display_ctrl #(.NUM_DIGITS(1), .BLINK_DIV(4)) dut1 (
      .clk        (clk),
      .reset      (reset),
      .value_in   (value_in1),
      .load       (load1),
      .blank_lz   (blank_lz1),
      .blink_en   (1'b0),
      .blink_mask (1'b0),
      .ready      (ready1),
      .done       (done1),
      .hex_out    (hex_out1)
   );

   // Free-running 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] tb_seg(input logic [3:0] n);
      case (n)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h18;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h27;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   function automatic logic [41:0] model6(input logic [23:0] v, input logic blz);
      logic [41:0] r;
      logic        seen;
      logic [3:0]  n;
      r    = '0;
      seen = 1'b0;
      for (int d = 5; d >= 0; d--) begin
         n = v[4*d +: 4];
         if (blz && !seen && n == 4'h0 && d != 0) r[7*d +: 7] = 7'h7F;
         else                                     r[7*d +: 7] = tb_seg(n);
         if (n != 4'h0) seen = 1'b1;
      end
      return r;
   endfunction

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input bit sel, input logic [23:0] v, input logic blz);
      @(negedge clk);
      if (sel) begin
         value_in1 = v[3:0];
         blank_lz1 = blz;
         load1     = 1'b1;
         exp_q.push_back(42'(tb_seg(v[3:0])));
      end else begin
         value_in = v;
         blank_lz = blz;
         load     = 1'b1;
         exp_q.push_back(model6(v, blz));
      end
      @(negedge clk);
      load  = 1'b0;
      load1 = 1'b0;
   endtask

   task automatic wait_done(input bit sel, output int busy, output bit seen);
      busy = 0;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (sel ? done1 : done) begin
            seen = 1'b1;
            break;
         end
         if (!(sel ? ready1 : ready)) busy++;
         @(negedge clk);
      end
   endtask

   initial begin
      int          busy;
      bit          seen;
      int          mcnt;
      logic        mph;
      logic [41:0] all40;
      logic [41:0] blinked;
      logic [41:0] all7f;

      all40   = {6{7'h40}};
      blinked = {{5{7'h40}}, 7'h7F};
      all7f   = {6{7'h7F}};

      reset      = 1'b1;
      value_in   = '0;
      load       = 1'b0;
      blank_lz   = 1'b0;
      blink_en   = 1'b0;
      blink_mask = '0;
      value_in1  = '0;
      load1      = 1'b0;
      blank_lz1  = 1'b0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check_output("rst_hex", 64'(hex_out), 64'(all7f));
      check_output("rst_ready", 64'(ready), 64'(1));
      check_output("rst_done", 64'(done), 64'(0));
      check_output("rst_hex1", 64'(hex_out1), 64'(7'h7F));
      check_output("rst_ready1", 64'(ready1), 64'(1));
      reset = 1'b0;

      // 0x00012F with leading-zero blanking, plus scan timing
      apply_stimulus(1'b0, 24'h00012F, 1'b1);
      wait_done(1'b0, busy, seen);
      check_output("t1_done_seen", 64'(seen), 64'(1));
      check_output("t1_busy", 64'(busy), 64'(6));
      check_output("t1_hex", 64'(hex_out), 64'(exp_q.pop_front()));
      @(negedge clk);
      check_output("t1_done_pulse", 64'(done), 64'(0));
      check_output("t1_ready", 64'(ready), 64'(1));

      // Zero with blanking leaves a single 0
      apply_stimulus(1'b0, 24'h000000, 1'b1);
      wait_done(1'b0, busy, seen);
      check_output("t2_done_seen", 64'(seen), 64'(1));
      check_output("t2_hex", 64'(hex_out), 64'(exp_q.pop_front()));

      // Busy load ignored; partial display mid-scan; load on done cycle accepted
      apply_stimulus(1'b0, 24'hABCDEF, 1'b0);
      @(negedge clk);
      value_in = 24'h123456;
      load     = 1'b1;
      @(negedge clk);
      load = 1'b0;
      @(negedge clk);
      check_output("t3_partial", 64'(hex_out),
                   64'({7'h08, 7'h03, 7'h27, 7'h7F, 7'h7F, 7'h40}));
      wait_done(1'b0, busy, seen);
      check_output("t3_done_seen", 64'(seen), 64'(1));
      check_output("t3_hex", 64'(hex_out), 64'(exp_q.pop_front()));
      value_in = 24'h000000;
      blank_lz = 1'b0;
      load     = 1'b1;
      exp_q.push_back(model6(24'h000000, 1'b0));
      @(negedge clk);
      load = 1'b0;
      check_output("t3_done_cycle_accept", 64'(ready), 64'(0));
      wait_done(1'b0, busy, seen);
      check_output("t2b_done_seen", 64'(seen), 64'(1));
      check_output("t2b_hex", 64'(hex_out), 64'(exp_q.pop_front()));

      // Blinking digit 0 with a four-cycle phase
      @(negedge clk);
      blink_en   = 1'b1;
      blink_mask = 6'b000001;
      mcnt       = 0;
      mph        = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         if (mcnt == 3) begin
            mcnt = 0;
            mph  = ~mph;
         end else begin
            mcnt++;
         end
         @(negedge clk);
         check_output("blink", 64'(hex_out), 64'(mph ? blinked : all40));
      end
      blink_en = 1'b0;
      @(negedge clk);
      check_output("blink_off", 64'(hex_out), 64'(all40));
      blink_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_output("blink_phase0", 64'(hex_out), 64'(all40));
      end
      @(negedge clk);
      check_output("blink_phase1", 64'(hex_out), 64'(blinked));
      blink_en   = 1'b0;
      blink_mask = '0;

      // Asynchronous reset three edges into a scan
      apply_stimulus(1'b0, 24'h654321, 1'b0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_output("mid_rst_hex", 64'(hex_out), 64'(all7f));
      check_output("mid_rst_ready", 64'(ready), 64'(1));
      check_output("mid_rst_done", 64'(done), 64'(0));
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      apply_stimulus(1'b0, 24'h654321, 1'b0);
      wait_done(1'b0, busy, seen);
      check_output("t5_done_seen", 64'(seen), 64'(1));
      check_output("t5_busy", 64'(busy), 64'(6));
      check_output("t5_hex", 64'(hex_out), 64'(exp_q.pop_front()));

      // Single-digit instance: every encoding, blanking never applies
      for (int v = 0; v < 16; v++) begin
         apply_stimulus(1'b1, 24'(v), 1'b1);
         wait_done(1'b1, busy, seen);
         check_output("d1_done_seen", 64'(seen), 64'(1));
         check_output("d1_busy", 64'(busy), 64'(1));
         check_output("d1_hex", 64'(hex_out1), 64'(exp_q.pop_front()));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
